// File: rtl/pico_mmio_ctrl_pkg.sv
// Shared constants for the pico MMIO controller: default addresses,
// control-window register offsets and status bit positions.
package pico_mmio_pkg;

  localparam logic [31:0] DEF_PRINT_ADDR = 32'h1000_0000;
  localparam logic [31:0] DEF_CTRL_BASE  = 32'h2000_0000;

  localparam logic [31:0] OFF_FINISH   = 32'h0;
  localparam logic [31:0] OFF_EXIT     = 32'h4;
  localparam logic [31:0] OFF_TIMER_LO = 32'h8;
  localparam logic [31:0] OFF_TIMER_HI = 32'hC;

  localparam int unsigned STAT_FULL_BIT     = 0;
  localparam int unsigned STAT_COUNT_LSB    = 1;
  localparam int unsigned FINISH_HALTED_BIT = 0;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_PRINT,
    REG_FINISH,
    REG_EXIT,
    REG_TIMER_LO,
    REG_TIMER_HI
  } reg_sel_e;

endpackage

// File: rtl/pico_mmio_ctrl_if.sv
// Core native memory bus as seen by the MMIO controller.
interface pico_mmio_ctrl_if;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mmio_sel;
  logic        mmio_ready;
  logic [31:0] mmio_rdata;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mmio_sel, mmio_ready, mmio_rdata
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mmio_sel, mmio_ready, mmio_rdata
  );
endinterface

// File: rtl/pico_mmio_ctrl_print_fifo.sv
// Synchronous FIFO with occupancy count and synchronous flush.
module pico_print_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  output logic                           full,
  input  logic                           pop,
  output logic                           valid,
  output logic [WIDTH-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign valid   = (count_q != '0);
  assign count   = count_q;
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & valid & ~flush;
  assign head    = valid ? mem_q[rd_ptr_q] : '0;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/pico_mmio_ctrl.sv
// MMIO controller: buffered print stream, finish/halt register with exit
// code, and a 64-bit cycle timer with an atomic high-word snapshot.
module pico_mmio_ctrl
  import pico_mmio_pkg::*;
#(
  parameter logic [31:0] PRINT_ADDR  = DEF_PRINT_ADDR,
  parameter logic [31:0] CTRL_BASE   = DEF_CTRL_BASE,
  parameter int unsigned CTRL_SPAN   = 16,
  parameter int unsigned PRINT_DEPTH = 8,
  parameter int unsigned PRINT_WIDTH = 8,
  parameter logic [63:0] TIMER_INIT  = '0
) (
  input  logic                   clk,
  input  logic                   resetn,
  pico_mmio_ctrl_if.slave        bus,
  input  logic                   conf_sel,
  output logic                   core_resetn,
  output logic                   print_valid,
  input  logic                   print_ready,
  output logic [PRINT_WIDTH-1:0] print_value,
  output logic                   done,
  output logic [7:0]             exit_code
);

  localparam int unsigned CW = $clog2(PRINT_DEPTH+1);

  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done_q, done_d;
  logic [7:0]  exit_q, exit_d;
  logic        halted_q, halted_d;
  logic [63:0] timer_q, timer_d;
  logic [31:0] shadow_q, shadow_d;

  logic [31:0] ctrl_off;
  logic        in_ctrl, is_write, stall, accept, push;
  logic        fifo_full;
  logic [CW-1:0] fifo_count;
  reg_sel_e    sel_reg;
  logic        unused_wdata;

  assign ctrl_off     = bus.mem_addr - CTRL_BASE;
  assign in_ctrl      = (ctrl_off < 32'(CTRL_SPAN));
  assign is_write     = |bus.mem_wstrb;
  assign unused_wdata = ^bus.mem_wdata;

  always_comb begin
    sel_reg = REG_NONE;
    if (bus.mem_addr == PRINT_ADDR) begin
      sel_reg = REG_PRINT;
    end else if (in_ctrl) begin
      case (ctrl_off)
        OFF_FINISH:   sel_reg = REG_FINISH;
        OFF_EXIT:     sel_reg = REG_EXIT;
        OFF_TIMER_LO: sel_reg = REG_TIMER_LO;
        OFF_TIMER_HI: sel_reg = REG_TIMER_HI;
        default:      sel_reg = REG_NONE;
      endcase
    end
  end

  assign bus.mmio_sel = bus.mem_valid & ((sel_reg == REG_PRINT) | in_ctrl);
  // Stall looks at the registered full flag, so a same-cycle pop cannot free space.
  assign stall  = (sel_reg == REG_PRINT) & is_write & fifo_full;
  assign accept = bus.mmio_sel & ~ready_q & ~stall;

  always_comb begin
    ready_d  = accept;
    rdata_d  = '0;
    done_d   = 1'b0;
    exit_d   = exit_q;
    halted_d = halted_q;
    timer_d  = halted_q ? timer_q : timer_q + 64'd1;
    shadow_d = shadow_q;
    push     = 1'b0;
    if (accept) begin
      if (is_write) begin
        case (sel_reg)
          REG_PRINT:  push = 1'b1;
          REG_FINISH: begin
            halted_d = 1'b1;
            exit_d   = bus.mem_wdata[7:0];
            done_d   = 1'b1;
          end
          default: ;
        endcase
      end else begin
        case (sel_reg)
          REG_PRINT: begin
            rdata_d[STAT_FULL_BIT]   = fifo_full;
            rdata_d[31:STAT_COUNT_LSB] = 31'(fifo_count);
          end
          REG_FINISH:   rdata_d[FINISH_HALTED_BIT] = halted_q;
          REG_EXIT:     rdata_d = {24'b0, exit_q};
          REG_TIMER_LO: begin
            rdata_d  = timer_q[31:0];
            shadow_d = timer_q[63:32];
          end
          REG_TIMER_HI: rdata_d = shadow_q;
          default: ;
        endcase
      end
    end
    // Host configuration mode overrides anything the bus did this cycle.
    if (conf_sel) begin
      halted_d = 1'b0;
      timer_d  = '0;
      shadow_d = '0;
      done_d   = 1'b0;
      exit_d   = exit_q;
      push     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      done_q   <= 1'b0;
      exit_q   <= '0;
      halted_q <= 1'b0;
      timer_q  <= TIMER_INIT;
      shadow_q <= '0;
    end else begin
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
      done_q   <= done_d;
      exit_q   <= exit_d;
      halted_q <= halted_d;
      timer_q  <= timer_d;
      shadow_q <= shadow_d;
    end
  end

  pico_print_fifo #(
    .DEPTH (PRINT_DEPTH),
    .WIDTH (PRINT_WIDTH)
  ) u_print_fifo (
    .clk       (clk),
    .rst_n     (resetn),
    .flush     (conf_sel),
    .push      (push),
    .push_data (bus.mem_wdata[PRINT_WIDTH-1:0]),
    .full      (fifo_full),
    .pop       (print_ready),
    .valid     (print_valid),
    .head      (print_value),
    .count     (fifo_count)
  );

  assign bus.mmio_ready = ready_q;
  assign bus.mmio_rdata = rdata_q;
  assign done           = done_q;
  assign exit_code      = exit_q;
  assign core_resetn    = resetn & ~conf_sel & ~halted_q;

endmodule

// File: tb/tb_pico_mmio_ctrl.sv
// Scoreboard bench for pico_mmio_ctrl: bus responses and print stream are
// checked against expectations queued when stimulus is driven.
module tb_pico_mmio_ctrl;
  import pico_mmio_pkg::*;

  localparam logic [31:0] PA    = 32'h1000_0000;
  localparam logic [31:0] CB    = 32'h2000_0000;
  localparam logic [63:0] TINIT = 64'h0000_0001_FFFF_FFF9;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       conf_sel = 1'b0;
  logic       print_ready = 1'b0;
  logic       core_resetn, print_valid, done;
  logic [7:0] print_value, exit_code;

  pico_mmio_ctrl_if bif ();

  pico_mmio_ctrl #(
    .PRINT_ADDR  (PA),
    .CTRL_BASE   (CB),
    .CTRL_SPAN   (32),
    .PRINT_DEPTH (8),
    .PRINT_WIDTH (8),
    .TIMER_INIT  (TINIT)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .bus         (bif),
    .conf_sel    (conf_sel),
    .core_resetn (core_resetn),
    .print_valid (print_valid),
    .print_ready (print_ready),
    .print_value (print_value),
    .done        (done),
    .exit_code   (exit_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  char_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cnt;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) cnt <= 0;
    else         cnt <= cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    #1;
    if (bif.mmio_ready !== 1'b0) begin
      if (exp_q.size() == 0) chk("unexpected_ready", 64'(bif.mmio_ready), 0);
      else begin
        e = exp_q.pop_front();
        chk(e.tag, 64'(bif.mmio_rdata), 64'(e.data));
      end
    end
  end

  always @(negedge clk) begin
    logic [7:0] c;
    #2;
    if (print_valid && print_ready) begin
      if (char_q.size() == 0) chk("unexpected_print", 64'(print_valid), 0);
      else begin
        c = char_q.pop_front();
        chk("print_value", 64'(print_value), 64'(c));
      end
    end
  end

  task automatic bus_req(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic [31:0] exp, input string tag);
    exp_t e;
    e.tag  = tag;
    e.data = exp;
    exp_q.push_back(e);
    bif.mem_addr  = addr;
    bif.mem_wdata = wdata;
    bif.mem_wstrb = strb;
    bif.mem_valid = 1'b1;
  endtask

  task automatic bus_ack(input string tag);
    int lat = 0;
    while (bif.mmio_ready !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 1);
    bif.mem_valid = 1'b0;
    bif.mem_wstrb = '0;
  endtask

  task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [31:0] exp, input string tag);
    bus_req(addr, wdata, strb, exp, tag);
    bus_ack(tag);
    @(negedge clk);
  endtask

  task automatic put_char(input logic [7:0] c);
    char_q.push_back(c);
    bus_xfer(PA, {24'hDEADBE, c}, 4'hF, 32'h0, "print_wr");
  endtask

  task automatic drain();
    print_ready = 1'b1;
    repeat (12) @(negedge clk);
    print_ready = 1'b0;
    chk("drain_empty", 64'(char_q.size()), 0);
    chk("drain_valid", 64'(print_valid), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] t, snap;
    int unsigned ef;
    bif.mem_valid = 1'b0;
    bif.mem_addr  = '0;
    bif.mem_wdata = '0;
    bif.mem_wstrb = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(bif.mmio_ready), 0);
    chk("rst_rdata", 64'(bif.mmio_rdata), 0);
    chk("rst_print_valid", 64'(print_valid), 0);
    chk("rst_print_value", 64'(print_value), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_exit", 64'(exit_code), 0);
    chk("rst_core_resetn", 64'(core_resetn), 0);
    resetn = 1'b1;
    #1 chk("core_resetn_up", 64'(core_resetn), 1);

    @(negedge clk);
    bif.mem_addr = PA; bif.mem_valid = 1'b1;
    #1 chk("sel_print", 64'(bif.mmio_sel), 1);
    bif.mem_addr = PA + 32'h4;
    #1 chk("sel_print_plus4", 64'(bif.mmio_sel), 0);
    bif.mem_addr = CB + 32'h1C;
    #1 chk("sel_ctrl_last", 64'(bif.mmio_sel), 1);
    bif.mem_addr = CB + 32'h20;
    #1 chk("sel_ctrl_past", 64'(bif.mmio_sel), 0);
    bif.mem_valid = 1'b0;

    // Timer snapshot: LO read near the 32-bit carry, HI read three cycles later.
    for (int i = 0; i < 40 && cnt != 5; i++) @(negedge clk);
    t = TINIT + 64'(cnt);
    snap = t;
    bus_xfer(CB + 32'h8, 32'h0, 4'h0, t[31:0], "timer_lo");
    @(negedge clk);
    bus_xfer(CB + 32'hC, 32'h0, 4'h0, snap[63:32], "timer_hi_snapshot");
    t = TINIT + 64'(cnt);
    bus_xfer(CB + 32'h8, 32'h0, 4'h0, t[31:0], "timer_lo_wrapped");
    bus_xfer(CB + 32'hC, 32'h0, 4'h0, t[63:32], "timer_hi_wrapped");
    bus_xfer(CB + 32'h8, 32'h1234_5678, 4'hF, 32'h0, "timer_wr_ignored");
    t = TINIT + 64'(cnt);
    bus_xfer(CB + 32'h8, 32'h0, 4'h0, t[31:0], "timer_lo_after_wr");

    // Single character with consumer ready.
    print_ready = 1'b1;
    char_q.push_back(8'h48);
    bus_req(PA, 32'hFFFF_FF48, 4'hF, 32'h0, "print_h");
    bus_ack("print_h");
    chk("h_valid", 64'(print_valid), 1);
    chk("h_value", 64'(print_value), 64'h48);
    @(negedge clk);
    chk("h_popped", 64'(print_valid), 0);
    print_ready = 1'b0;

    // Fill the FIFO, then stall the ninth write until one pop frees a slot.
    for (int i = 0; i < 8; i++) put_char(8'h41 + 8'(i));
    bus_xfer(PA, 32'h0, 4'h0, 32'h11, "status_full");
    char_q.push_back(8'h49);
    bus_req(PA, 32'h0000_0049, 4'h1, 32'h0, "print_wr9");
    repeat (3) begin
      @(negedge clk);
      chk("stall_no_ready", 64'(bif.mmio_ready), 0);
    end
    print_ready = 1'b1;
    @(negedge clk);
    print_ready = 1'b0;
    chk("pop_no_unblock", 64'(bif.mmio_ready), 0);
    @(negedge clk);
    chk("stall_release", 64'(bif.mmio_ready), 1);
    bif.mem_valid = 1'b0;
    bif.mem_wstrb = '0;
    @(negedge clk);
    bus_xfer(PA, 32'h0, 4'h0, 32'h11, "status_refill");
    drain();

    for (int i = 0; i < 3; i++) put_char(8'h61 + 8'(i));
    bus_xfer(PA, 32'h0, 4'h0, 32'h6, "status_three");
    bus_xfer(PA, 32'h0, 4'h0, 32'h6, "status_three_again");
    drain();

    // Finish with a character left queued, then host configuration.
    put_char(8'h5A);
    ef = cnt;
    bus_req(CB, 32'hDEAD_BE2A, 4'b0001, 32'h0, "finish_wr");
    bus_ack("finish_wr");
    chk("finish_done", 64'(done), 1);
    chk("finish_exit", 64'(exit_code), 64'h2A);
    chk("finish_core_resetn", 64'(core_resetn), 0);
    @(negedge clk);
    chk("done_pulse_end", 64'(done), 0);
    t = TINIT + 64'(ef) + 64'd1;
    bus_xfer(CB + 32'h8, 32'h0, 4'h0, t[31:0], "timer_frozen");
    bus_xfer(CB + 32'h8, 32'h0, 4'h0, t[31:0], "timer_frozen_again");
    bus_xfer(CB, 32'h0, 4'h0, 32'h1, "finish_rd_halted");
    bus_xfer(CB + 32'h4, 32'h0, 4'h0, 32'h2A, "exit_rd");

    conf_sel = 1'b1;
    #1 chk("conf_core_resetn", 64'(core_resetn), 0);
    @(negedge clk);
    conf_sel = 1'b0;
    char_q.delete();
    bus_xfer(CB + 32'h8, 32'h0, 4'h0, 32'h0, "timer_cleared");
    chk("conf_released_core", 64'(core_resetn), 1);
    chk("conf_flushed", 64'(print_valid), 0);
    bus_xfer(PA, 32'h0, 4'h0, 32'h0, "status_flushed");
    bus_xfer(CB, 32'h0, 4'h0, 32'h0, "finish_rd_cleared");
    bus_xfer(CB + 32'h4, 32'h0, 4'h0, 32'h2A, "exit_retained");
    bus_xfer(CB + 32'hC, 32'h0, 4'h0, 32'h0, "shadow_cleared");

    bus_xfer(CB + 32'h10, 32'h0, 4'h0, 32'h0, "unmapped_rd");
    bus_xfer(CB + 32'h14, 32'hFFFF_FFFF, 4'hF, 32'h0, "unmapped_wr");
    bus_xfer(CB + 32'h4, 32'h0, 4'h0, 32'h2A, "exit_after_unmapped");

    // Reset right after an accept: the pending response must vanish.
    put_char(8'h31);
    put_char(8'h32);
    bif.mem_addr  = CB + 32'h10;
    bif.mem_wstrb = 4'h0;
    bif.mem_valid = 1'b1;
    @(posedge clk);
    #1;
    resetn = 1'b0;
    bif.mem_valid = 1'b0;
    char_q.delete();
    @(negedge clk);
    chk("midrst_ready", 64'(bif.mmio_ready), 0);
    chk("midrst_rdata", 64'(bif.mmio_rdata), 0);
    chk("midrst_print_valid", 64'(print_valid), 0);
    chk("midrst_print_value", 64'(print_value), 0);
    chk("midrst_done", 64'(done), 0);
    chk("midrst_exit", 64'(exit_code), 0);
    chk("midrst_core_resetn", 64'(core_resetn), 0);
    repeat (2) begin
      @(negedge clk);
      chk("midrst_no_ready", 64'(bif.mmio_ready), 0);
    end
    resetn = 1'b1;
    @(negedge clk);
    bus_xfer(CB, 32'h0, 4'h0, 32'h0, "finish_after_rst");
    t = TINIT + 64'(cnt);
    bus_xfer(CB + 32'h8, 32'h0, 4'h0, t[31:0], "timer_after_rst");
    chk("sb_empty", 64'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pico_mmio_ctrl.md
Name: pico_mmio_ctrl

Overview:
- Parametrised memory-mapped I/O controller between the RV32I core's native memory bus and the SoC top. It replaces the ad-hoc print/finish logic.
- Provides:
  - a buffered, back-pressured print stream through a FIFO;
  - a finish/halt register with a latched exit code;
  - a 64-bit cycle timer readable by software with an atomic snapshot of the high word.
- The top muxes mem_ready/mem_rdata from this block whenever mmio_sel is high. Otherwise the memory responds.

Parameters:
- PRINT_ADDR, 32'h1000_0000: print data/status register.
- CTRL_BASE, 32'h2000_0000: base of the control window. FINISH=+0x0, EXIT_CODE=+0x4, TIMER_LO=+0x8, TIMER_HI=+0xC.
- CTRL_SPAN, 16: bytes decoded in the control window. Unmapped words read 0.
- PRINT_DEPTH, 8: print FIFO entries. Power of two, ≥2.
- PRINT_WIDTH, 8: print character width, ≤32.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- mem_valid  in  1  core request valid, held until mmio_ready
- mem_addr  in  32  byte address
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte strobes. Nonzero means write, zero means read.
- mmio_sel  out  1  combinational: mem_valid & address in MMIO map
- mmio_ready  out  1  one-cycle response pulse
- mmio_rdata  out  32  read data, valid with mmio_ready
- conf_sel  in  1  host configuration mode; clears halt and timer
- core_resetn  out  1  resetn & ~conf_sel & ~halted
- print_valid  out  1  FIFO head valid
- print_ready  in  1  consumer accepts head
- print_value  out  PRINT_WIDTH  FIFO head data
- done  out  1  one-cycle pulse when halt is set
- exit_code  out  8  mem_wdata[7:0] latched on the FINISH write

Behaviour:
- Reset values: mmio_ready=0, mmio_rdata=0, print_valid=0, print_value=0, done=0, exit_code=0, halted=0, timer=0, FIFO empty. core_resetn follows resetn combinationally.
- Accept condition: mem_valid & mmio_sel & ~mmio_ready & ~stall.
  - stall = write to PRINT_ADDR while the FIFO is full.
  - mmio_ready is registered and rises exactly 1 cycle after accept.
  - The cycle after the ready pulse can never be an accept for the same request, because ~mmio_ready gates it.
- Print write: push mem_wdata[PRINT_WIDTH-1:0]; the upper bits are ignored.
  - Full FIFO: no accept, no ready. Push happens the first cycle the FIFO is not full at a clock edge.
  - A pop in the same cycle does NOT unblock a push in that cycle.
- Print read: returns {count zero-extended to 31 bits in [31:1], full in [0]}. It does not pop.
- FIFO stream: print_value is valid whenever print_valid=1; pop on print_valid & print_ready.
  - Pointers wrap modulo PRINT_DEPTH.
  - count width is $clog2(PRINT_DEPTH+1).
  - Simultaneous push and pop when non-empty and non-full: count unchanged.
- FINISH write (any strobe): halted<=1, exit_code<=wdata[7:0], done pulses 1 cycle, ready is given.
  - core_resetn drops one cycle after accept.
  - A FINISH write while already halted is impossible, since the core is in reset.
- EXIT_CODE read: {24'b0, exit_code}. FINISH read returns {31'b0, halted}.
- Timer: 64-bit counter that increments every cycle while ~halted & ~conf_sel. It wraps from 2^64-1 to 0.
  - TIMER_LO read returns timer[31:0] and captures timer[63:32] into a shadow register in the same cycle.
  - TIMER_HI read returns the shadow value, not the live high word.
  - Writes to timer registers are ignored but acknowledged.
- conf_sel=1: halted<=0, timer<=0, shadow<=0, FIFO flushed. conf_sel has priority over every simultaneous event. exit_code is retained.
- Unmapped address inside the control window: read returns 0, write is ignored, ready after 1 cycle.
- Reset asserted mid-transaction: all state clears immediately and no ready pulse follows.
- Byte strobes are ignored for all registers. Any nonzero strobe is treated as a full write.

Decomposition:
- Package pico_mmio_pkg:
  - register offset localparams (OFF_FINISH, OFF_EXIT, OFF_TIMER_LO, OFF_TIMER_HI);
  - default addresses;
  - status bit positions.
- Sub-module pico_print_fifo: synchronous FIFO parametrised by DEPTH and WIDTH, with push/full/pop/valid/count/flush ports. It is reused by future UART blocks.

Test Plan:
- Write 'H' (0x48) to 0x1000_0000 with print_ready=1 → mmio_ready 1 cycle after accept; print_valid=1, print_value=0x48 the next cycle; popped the same cycle.
- print_ready=0, write 9 chars with depth 8 → first 8 acked; 9th stalls with mmio_ready=0. Raise print_ready for 1 cycle → 9th acked. Output order is preserved.
- Read 0x1000_0000 holding 3 queued entries → rdata=0x0000_0006, FIFO unchanged.
- Force timer to 0x0000_0001_FFFF_FFFE. Read TIMER_LO, then TIMER_HI 3 cycles later → HI returns 0x1, not 0x2.
- Write 0x2A to 0x2000_0000 → done pulse; exit_code=0x2A; core_resetn=0 the next cycle; timer frozen. Pulse conf_sel → halted=0, timer=0, exit_code still 0x2A.
- Read 0x2000_0010 with CTRL_SPAN=32 → rdata=0, one ready pulse. Assert resetn=0 the cycle after accept → no ready pulse, all outputs at reset values.
